// File: rtl/plc_timer_pkg.sv
// Shared constants and types for the PLC on-delay timer scheduler.
package plc_timer_pkg;

  localparam int N_SLOTS_DEF = 8;
  localparam int ACC_W_DEF   = 32;
  localparam int TICK_HZ     = 1000;
  localparam int IDX_W_DEF   = $clog2(N_SLOTS_DEF);

  typedef logic [IDX_W_DEF-1:0] slot_idx_t;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the 1 kHz tick level.
// The history flop resets high so a tick already high at release is not an edge.
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  output logic o_edge
);

  logic r_tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_q <= 1'b1;
    end else begin
      r_tick_q <= i_tick;
    end
  end

  assign o_edge = i_tick & ~r_tick_q;

endmodule

// File: rtl/ton_scan_sched.sv
// Round-robin TON timer bank sharing one compare/increment datapath.
// Define TON_SCAN_OVERRUN_EN to build the sticky missed-tick detector.
module ton_scan_sched
  import plc_timer_pkg::*;
#(
  parameter  int N_SLOTS = N_SLOTS_DEF,
  parameter  int ACC_W   = ACC_W_DEF,
  localparam int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [N_SLOTS-1:0] in_en,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [ACC_W-1:0]   cfg_pre,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ACC_W-1:0]   rd_acc,
  output logic [N_SLOTS-1:0] en,
  output logic [N_SLOTS-1:0] dn,
  output logic [N_SLOTS-1:0] tt,
  output logic               overrun
);

  logic [N_SLOTS-1:0][ACC_W-1:0] r_acc;
  logic [N_SLOTS-1:0][ACC_W-1:0] r_pre;
  logic [N_SLOTS-1:0]            r_pend;
  logic [N_SLOTS-1:0]            r_en;
  logic [N_SLOTS-1:0]            r_dn;
  logic [N_SLOTS-1:0]            r_tt;
  logic [IDX_W-1:0]              r_ptr;
  logic [ACC_W-1:0]              r_rd_acc;

  logic                          w_tick_edge;
  logic [ACC_W-1:0]              w_acc;
  logic [ACC_W-1:0]              w_pre;
  logic [ACC_W-1:0]              w_acc_nx;
  logic                          w_inc;
  logic [N_SLOTS-1:0]            w_eval;

  tick_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_tick (tick),
    .o_edge (w_tick_edge)
  );

  // Shared datapath: only the slot under the pointer is evaluated.
  assign w_acc    = r_acc[r_ptr];
  assign w_pre    = r_pre[r_ptr];
  assign w_inc    = r_pend[r_ptr] && (w_acc < w_pre);
  assign w_acc_nx = w_inc ? w_acc + ACC_W'(1) : w_acc;

  always_comb begin
    w_eval        = '0;
    w_eval[r_ptr] = in_en[r_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_ptr == IDX_W'(N_SLOTS - 1)) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_pre    <= '0;
      r_pend   <= '0;
      r_en     <= '0;
      r_dn     <= '0;
      r_tt     <= '0;
      r_rd_acc <= '0;
    end else begin
      r_en     <= in_en;
      r_rd_acc <= r_acc[rd_idx];
      for (int i = 0; i < N_SLOTS; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          r_pre[i] <= cfg_pre;
        end
        if (!in_en[i]) begin
          r_acc[i]  <= '0;
          r_pend[i] <= 1'b0;
          r_dn[i]   <= 1'b0;
          r_tt[i]   <= 1'b0;
        end else begin
          if (w_eval[i]) begin
            r_acc[i] <= w_acc_nx;
            r_dn[i]  <= (w_acc_nx >= w_pre);
            r_tt[i]  <= (w_acc_nx < w_pre);
          end
          // A fresh tick beats the clear from this visit.
          r_pend[i] <= w_tick_edge | (r_pend[i] & ~w_eval[i]);
        end
      end
    end
  end

`ifdef TON_SCAN_OVERRUN_EN
  logic r_ovr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_tick_edge && (|(r_pend & ~w_eval))) begin
      r_ovr <= 1'b1;
    end
  end

  assign overrun = r_ovr;
`else
  assign overrun = 1'b0;
`endif

  assign rd_acc = r_rd_acc;
  assign en     = r_en;
  assign dn     = r_dn;
  assign tt     = r_tt;

endmodule

// File: tb/tb_ton_scan_sched.sv
// Scoreboard bench for ton_scan_sched: expectations queued at drive time,
// compared one clock edge later against the registered outputs.
module tb_ton_scan_sched;
  import plc_timer_pkg::*;

  localparam int N  = 8;
  localparam int AW = 32;
`ifdef TON_SCAN_OVERRUN_EN
  localparam logic [31:0] OVR_EXP = 32'd1;
`else
  localparam logic [31:0] OVR_EXP = 32'd0;
`endif

  typedef enum int {K_ACC, K_EN, K_DN, K_TT, K_OVR} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [N-1:0]  in_en;
  logic          cfg_we;
  slot_idx_t     cfg_idx;
  logic [AW-1:0] cfg_pre;
  slot_idx_t     rd_idx;
  logic [AW-1:0] rd_acc;
  logic [N-1:0]  en;
  logic [N-1:0]  dn;
  logic [N-1:0]  tt;
  logic          overrun;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];

  ton_scan_sched #(.N_SLOTS(N), .ACC_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .in_en   (in_en),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_pre (cfg_pre),
    .rd_idx  (rd_idx),
    .rd_acc  (rd_acc),
    .en      (en),
    .dn      (dn),
    .tt      (tt),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Pointer value for the upcoming edge is cyc % N.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t        e;
    logic [31:0] got;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_ACC:   got = rd_acc;
        K_EN:    got = 32'(en[e.idx]);
        K_DN:    got = 32'(dn[e.idx]);
        K_TT:    got = 32'(tt[e.idx]);
        default: got = 32'(overrun);
      endcase
      chk(e.tag, got, e.exp);
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic go_ptr(input int p);
    nxt();
    for (int k = 0; k < N && (cyc % N) != p; k++) nxt();
  endtask

  task automatic sb_push(input string tag, input kind_e kind,
                         input int idx, input logic [31:0] exp);
    exp_t e;
    if (kind == K_ACC) rd_idx = slot_idx_t'(idx);
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
  endtask

  task automatic wr_pre(input int idx, input logic [AW-1:0] v);
    cfg_we  = 1'b1;
    cfg_idx = slot_idx_t'(idx);
    cfg_pre = v;
    nxt();
    cfg_we  = 1'b0;
  endtask

  // Tick edge at ptr 5; slot 3 is visited at ptr 3; read at ptr 4.
  task automatic tick_and_read3();
    go_ptr(5);
    tick_pulse();
    go_ptr(4);
  endtask

  initial begin
    rst     = 1'b1;
    tick    = 1'b0;
    in_en   = '0;
    cfg_we  = 1'b0;
    cfg_idx = '0;
    cfg_pre = '0;
    rd_idx  = '0;
    nxt();
    sb_push("rst_acc", K_ACC, 0, 0);
    sb_push("rst_en3", K_EN,  3, 0);
    sb_push("rst_dn3", K_DN,  3, 0);
    sb_push("rst_tt3", K_TT,  3, 0);
    sb_push("rst_ovr", K_OVR, 0, 0);
    nxt();
    rst = 1'b0;

    wr_pre(3, 5);
    in_en = 8'h08;
    for (int kk = 1; kk <= 6; kk++) begin
      tick_and_read3();
      sb_push("cnt_acc3", K_ACC, 3, (kk > 5) ? 5 : kk);
      if (kk == 4) begin
        sb_push("cnt_dn3_lo", K_DN, 3, 0);
        sb_push("cnt_tt3_hi", K_TT, 3, 1);
      end
      if (kk == 5) begin
        sb_push("cnt_dn3_hi", K_DN, 3, 1);
        sb_push("cnt_tt3_lo", K_TT, 3, 0);
      end
    end

    in_en = '0;
    nxt();
    in_en = 8'h08;
    for (int kk = 1; kk <= 3; kk++) tick_and_read3();
    sb_push("dis_acc3_pre", K_ACC, 3, 3);
    sb_push("dis_en3_pre",  K_EN,  3, 1);
    sb_push("dis_tt3_pre",  K_TT,  3, 1);
    nxt();
    in_en = '0;
    sb_push("dis_en3", K_EN, 3, 0);
    sb_push("dis_dn3", K_DN, 3, 0);
    sb_push("dis_tt3", K_TT, 3, 0);
    nxt();
    in_en = 8'h08;
    sb_push("dis_acc3", K_ACC, 3, 0);
    tick_and_read3();
    sb_push("dis_restart", K_ACC, 3, 1);

    go_ptr(5);
    tick_pulse();
    go_ptr(3);
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    sb_push("coll_tick_a", K_ACC, 3, 2);
    go_ptr(4);
    sb_push("coll_tick_b", K_ACC, 3, 3);
    go_ptr(4);
    sb_push("coll_tick_c", K_ACC, 3, 3);

    go_ptr(5);
    tick_pulse();
    go_ptr(3);
    wr_pre(3, 3);
    sb_push("coll_cfg_acc", K_ACC, 3, 4);
    sb_push("coll_cfg_dn",  K_DN,  3, 0);
    sb_push("coll_cfg_tt",  K_TT,  3, 1);
    go_ptr(4);
    sb_push("newpre_acc", K_ACC, 3, 4);
    sb_push("newpre_dn",  K_DN,  3, 1);
    sb_push("newpre_tt",  K_TT,  3, 0);

    wr_pre(3, 10);
    in_en = 8'h09;
    for (int kk = 1; kk <= 3; kk++) tick_and_read3();
    sb_push("lo_acc3_7", K_ACC, 3, 7);
    sb_push("ovr_idle",  K_OVR, 0, 0);
    nxt();
    sb_push("pre0_acc", K_ACC, 0, 0);
    sb_push("pre0_dn",  K_DN,  0, 1);
    sb_push("pre0_tt",  K_TT,  0, 0);
    wr_pre(3, 4);
    tick_and_read3();
    sb_push("lower_acc", K_ACC, 3, 7);
    sb_push("lower_dn",  K_DN,  3, 1);
    sb_push("lower_tt",  K_TT,  3, 0);

    go_ptr(5);
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    nxt();
    nxt();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    sb_push("ovr_set", K_OVR, 0, OVR_EXP);
    go_ptr(4);
    sb_push("ovr_sticky", K_OVR, 0, OVR_EXP);

    go_ptr(5);
    tick_pulse();
    tick = 1'b1;
    rst  = 1'b1;
    nxt();
    sb_push("mrst_acc3", K_ACC, 3, 0);
    sb_push("mrst_en3",  K_EN,  3, 0);
    sb_push("mrst_dn0",  K_DN,  0, 0);
    sb_push("mrst_tt3",  K_TT,  3, 0);
    sb_push("mrst_ovr",  K_OVR, 0, 0);
    nxt();
    rst = 1'b0;
    wr_pre(3, 5);
    repeat (16) nxt();
    sb_push("mrst_hold", K_ACC, 3, 0);
    tick = 1'b0;
    nxt();
    tick = 1'b1;
    nxt();
    tick = 1'b0;
    nxt();
    sb_push("mrst_ptr0", K_ACC, 3, 1);

    nxt();
    nxt();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ton_scan_sched.md
# ton_scan_sched

Round-robin scheduler for a bank of on-delay (TON) ladder timers that share one compare/increment datapath. Each rising edge of the 1 kHz `tick` marks every enabled slot as pending. A slot pointer visits one slot per `clk`, increments that slot's accumulator when it is pending, and refreshes its DN/TT flags. The block sits between the ladder rung logic, which drives the per-slot enables, and the PLC register map, which writes presets and reads accumulators.

## Interface
Parameters:
- `N_SLOTS`, default 8: number of timer slots (2..64).
- `ACC_W`, default 32: preset/accumulator width in bits (milliseconds).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  down-sampled 1 kHz clock, level signal.
- `in_en`  in  N_SLOTS  per-slot rung enable (IN).
- `cfg_we`  in  1  preset write strobe.
- `cfg_idx`  in  $clog2(N_SLOTS)  preset write slot.
- `cfg_pre`  in  ACC_W  preset value in ms.
- `rd_idx`  in  $clog2(N_SLOTS)  accumulator read slot.
- `rd_acc`  out  ACC_W  registered ACC of `rd_idx`.
- `en`  out  N_SLOTS  registered copy of `in_en`.
- `dn`  out  N_SLOTS  done flags.
- `tt`  out  N_SLOTS  timing flags.
- `overrun`  out  1  sticky missed-tick flag (only when TON_SCAN_OVERRUN_EN is defined).

## Operation
- **Reset:** `rst`=1 at a `clk` edge sets the following:
  - `acc[]`=0, `pre[]`=0, `pend`=0, `ptr`=0.
  - `tick_q`=1, so a tick already high at reset release does not count as an edge.
  - Outputs `en`/`dn`/`tt`/`rd_acc`/`overrun` all =0.
- **Tick edge:** `tick_edge` = `tick & ~tick_q`, and `tick_q` <= `tick` every cycle. On `tick_edge`, `pend[i]` is set for every i with `in_en[i]`=1.
- **Parallel disable** (every cycle, all slots, highest priority): when `in_en[i]`=0, then `acc[i]`<=0, `pend[i]`<=0, `dn[i]`<=0, `tt[i]`<=0. `en[i]` <= `in_en[i]` every cycle.
- **Scan:**
  - `ptr` advances by 1 every cycle and wraps from N_SLOTS-1 to 0; it never stalls.
  - Slot `p`=`ptr` is evaluated only if `in_en[p]`=1:
    - `acc_nx` = (`pend[p]` && `acc[p]` < `pre[p]`) ? `acc[p]`+1 : `acc[p]`.
    - `acc[p]` <= `acc_nx`; `dn[p]` <= (`acc_nx` >= `pre[p]`); `tt[p]` <= (`acc_nx` < `pre[p]`).
    - `pend[p]` is cleared.
- **Simultaneous eval clear and tick edge on the same slot:** the set wins. `pend[p]` ends at 1 and the new tick is kept.
- **Saturation:** ACC never exceeds PRE. If PRE is lowered below ACC, ACC holds its value and DN=1 on the next visit. Increment is ACC_W-bit unsigned with no wrap.
- **PRE=0:** an enabled slot shows DN=1, TT=0 on its first visit, and ACC stays 0.
- **Preset write:** `cfg_we` writes `pre[cfg_idx]` at the clock edge. An evaluation of the same slot in that cycle uses the old PRE; the new value applies from the next visit.
- **Read port:** `rd_acc` <= `acc[rd_idx]` (the pre-update value).

## Timing
- Each slot is visited every N_SLOTS cycles.
- A tick edge is reflected in ACC within N_SLOTS+1 cycles.
- DN/TT update only at a slot's visit, so they are stale for at most N_SLOTS cycles.
- Disable takes effect in 1 cycle (registered), independent of `ptr`.
- `rd_acc` latency is 1 cycle.
- Requirement: the `clk` period × N_SLOTS must be shorter than the tick period (1 ms).

## Configuration
- `TON_SCAN_OVERRUN_EN` defined:
  - `overrun` is set when `tick_edge` occurs while any `pend[i]` is 1 and that bit is not being cleared by evaluation in the same cycle.
  - The flag is sticky and cleared only by `rst`.
- Not defined: the overrun logic is removed and `overrun` is tied to 0. The port is kept for a stable register map.

## Structure
- Package `plc_timer_pkg` holds:
  - the default `ACC_W` and `N_SLOTS` values;
  - the `slot_idx_t` typedef;
  - the `TICK_HZ`=1000 constant.
- Sub-module `tick_edge_det` contains `tick_q` (reset value 1) and produces the 1-cycle `tick_edge` pulse.
- All other logic, including the pointer, pend vector, arrays and shared eval datapath, lives in `ton_scan_sched`.

## Test plan
- **Basic count:** N_SLOTS=8, `pre[3]`=5, `in_en[3]`=1, 5 tick edges → ACC3 reaches 5, TT3 1→0, DN3=1 within 9 cycles of the 5th edge. Further ticks leave ACC3 at 5.
- **Disable mid-count:** at ACC3=3, drop `in_en[3]` → next cycle ACC3=0, DN3=TT3=EN3=0. Re-enable → counting restarts from 0.
- **Pointer collision:**
  - A tick edge in the same cycle `ptr`=3 evaluates pending slot 3 → ACC3 increments once and `pend[3]` remains 1, giving one more increment on the next visit.
  - A `cfg_we` write to slot 3 in the cycle `ptr`=3 → the old PRE is used for that visit.
- **PRE=0 and PRE lowered:** `pre[0]`=0 with enable → DN0=1, ACC0=0. At ACC=7, write `pre`=4 → ACC stays 7 and DN=1.
- **Overrun (macro defined):** clk period ×8 > tick spacing, i.e. back-to-back tick edges 3 cycles apart → `overrun`=1 and it stays high until `rst`. With the macro undefined → `overrun`=0.
- **Reset mid-operation:** `rst` pulse during counting → all ACC/flags/pend=0 and `ptr`=0. `tick` held high across reset release → no increment until the next rising edge.
